// File: rtl/avr_command_decoder_pkg.sv
// Shared definitions for the AVR command decoder: command field layout, op codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a. make_cmd() builds a command word for benches and firmware header generation.
package avr_cmd_pkg;

  localparam int CMD_W   = 8;
  localparam int OP_W    = 2;
  localparam int OP_LSB  = 6;
  localparam int IDX_W   = 6;
  localparam int IDX_LSB = 0;

  // Index reserved for line-independent commands (NOP / RESTORE).
  localparam logic [IDX_W-1:0] IDX_SPECIAL = 6'h3F;

  typedef enum logic [OP_W-1:0] {
    OP_LO     = 2'b00,
    OP_HI     = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_PULSE  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_e;

  function automatic logic [CMD_W-1:0] make_cmd(op_e op, logic [IDX_W-1:0] idx);
    return {op, idx};
  endfunction

endpackage

// File: rtl/avr_command_decoder_if.sv
// Command port between the AVR pins and the decoder, plus the decoded control outputs.
// Latency: n/a (wiring only).
// Backpressure: none; one command per strobe rising edge, busy is advisory.
// master: AVR side drives avr_ctrl/avr_strobe. slave: decoder drives ctrl_lines, cmd_ack, cmd_err, busy.
interface avr_command_decoder_if #(
  parameter int NUM_LINES = 8
);
  import avr_cmd_pkg::*;

  logic [CMD_W-1:0]     avr_ctrl;
  logic                 avr_strobe;
  logic [NUM_LINES-1:0] ctrl_lines;
  logic                 cmd_ack;
  logic                 cmd_err;
  logic                 busy;

  modport master (
    output avr_ctrl, avr_strobe,
    input  ctrl_lines, cmd_ack, cmd_err, busy
  );

  modport slave (
    input  avr_ctrl, avr_strobe,
    output ctrl_lines, cmd_ack, cmd_err, busy
  );

endinterface

// File: rtl/avr_command_decoder_pulse_timer.sv
// Down-counter timing a single pulse: load starts it, done flags the last cycle, busy spans the pulse.
// Latency: busy rises one edge after load; done is high during the PULSE_CYCLES-th busy cycle.
// Backpressure: none; load is only issued while idle.
// Ports: avr_clk, reset (async high), load in, done out (combinational), busy out (registered).
module avr_pulse_timer #(
  parameter int PULSE_CYCLES = 4
) (
  input  logic avr_clk,
  input  logic reset,
  input  logic load,
  output logic done,
  output logic busy
);

  localparam logic [7:0] LOAD_VAL = 8'(PULSE_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      cnt_d  = LOAD_VAL;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge avr_clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 8'd0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == 8'd0);
  assign busy = busy_q;

endmodule

// File: rtl/avr_command_decoder.sv
// Decodes strobed 8-bit AVR commands into NUM_LINES registered control lines (lo/hi/toggle/pulse/restore).
// Latency: line update and cmd_ack/cmd_err registered on the edge that first samples the strobe high.
// Backpressure: none; conflicting commands during a pulse are rejected with cmd_err.
// Ports: avr_clk, reset (async high), bus (slave modport: avr_ctrl/avr_strobe in; ctrl_lines/cmd_ack/cmd_err/busy out).
module avr_command_decoder
  import avr_cmd_pkg::*;
#(
  parameter int                   NUM_LINES    = 8,
  parameter logic [NUM_LINES-1:0] RESET_VALUES = '0,
  parameter int                   PULSE_CYCLES = 4
) (
  input  logic                  avr_clk,
  input  logic                  reset,
  avr_command_decoder_if.slave  bus
);

  localparam logic [NUM_LINES-1:0] LINE_ONE  = NUM_LINES'(1);
  localparam logic [IDX_W-1:0]     IDX_LIMIT = IDX_W'(NUM_LINES);

  logic                 strobe_q, strobe_d;
  logic [NUM_LINES-1:0] lines_q, lines_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     pulse_line_q, pulse_line_d;
  logic                 saved_q, saved_d;

  logic                 cmd_evt;
  op_e                  op;
  logic [IDX_W-1:0]     idx;
  logic [NUM_LINES-1:0] cmd_mask;
  logic [NUM_LINES-1:0] pulse_mask;
  logic                 in_pulse;
  logic                 timer_load;
  logic                 timer_done;
  logic                 timer_busy;

  always_comb begin
    strobe_d     = bus.avr_strobe;
    lines_d      = lines_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    state_d      = state_q;
    pulse_line_d = pulse_line_q;
    saved_d      = saved_q;
    timer_load   = 1'b0;

    cmd_evt    = bus.avr_strobe && !strobe_q;
    op         = op_e'(bus.avr_ctrl[OP_LSB +: OP_W]);
    idx        = bus.avr_ctrl[IDX_LSB +: IDX_W];
    // One-hot masks avoid part-selects indexed by a 6-bit field on a narrower vector.
    cmd_mask   = LINE_ONE << idx;
    pulse_mask = LINE_ONE << pulse_line_q;
    in_pulse   = (state_q == ST_PULSE);

    if (cmd_evt) begin
      if (idx == IDX_SPECIAL) begin
        if (op == OP_LO) begin
          ack_d = 1'b1;
        end else if (op == OP_HI && !in_pulse) begin
          ack_d   = 1'b1;
          lines_d = RESET_VALUES;
        end else begin
          err_d = 1'b1;
        end
      end else if (idx >= IDX_LIMIT) begin
        err_d = 1'b1;
      end else if (op == OP_PULSE) begin
        if (in_pulse) begin
          err_d = 1'b1;
        end else begin
          ack_d        = 1'b1;
          lines_d      = lines_q ^ cmd_mask;
          saved_d      = |(lines_q & cmd_mask);
          pulse_line_d = idx;
          timer_load   = 1'b1;
          state_d      = ST_PULSE;
        end
      end else if (in_pulse && idx == pulse_line_q) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        case (op)
          OP_LO:   lines_d = lines_q & ~cmd_mask;
          OP_HI:   lines_d = lines_q | cmd_mask;
          default: lines_d = lines_q ^ cmd_mask;
        endcase
      end
    end

    // Pulse completion is applied last so the restore wins over any same-edge write.
    // A command on this edge was already judged against the pre-edge PULSE state above.
    if (in_pulse && timer_done) begin
      lines_d = saved_q ? (lines_d | pulse_mask) : (lines_d & ~pulse_mask);
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge avr_clk or posedge reset) begin
    if (reset) begin
      strobe_q     <= 1'b0;
      lines_q      <= RESET_VALUES;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      state_q      <= ST_IDLE;
      pulse_line_q <= '0;
      saved_q      <= 1'b0;
    end else begin
      strobe_q     <= strobe_d;
      lines_q      <= lines_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      state_q      <= state_d;
      pulse_line_q <= pulse_line_d;
      saved_q      <= saved_d;
    end
  end

  avr_pulse_timer #(
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_timer (
    .avr_clk (avr_clk),
    .reset   (reset),
    .load    (timer_load),
    .done    (timer_done),
    .busy    (timer_busy)
  );

  assign bus.ctrl_lines = lines_q;
  assign bus.cmd_ack    = ack_q;
  assign bus.cmd_err    = err_q;
  assign bus.busy       = timer_busy;

endmodule

// File: tb/tb_avr_command_decoder.sv
module tb_avr_command_decoder;
  import avr_cmd_pkg::*;

  typedef struct packed {
    logic       ok;
    logic [7:0] lines;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  exp_t exp_q[$];

  avr_command_decoder_if #(.NUM_LINES(8)) bus ();

  avr_command_decoder #(
    .NUM_LINES    (8),
    .RESET_VALUES (8'hA5),
    .PULSE_CYCLES (4)
  ) dut (
    .avr_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Drive one command; expectation is queued on drive and popped when ack/err appears.
  // hold = extra cycles the strobe stays high; no further ack/err may appear then.
  task automatic do_cmd(input string name, input logic [7:0] cmd, input logic exp_ok,
                        input logic [7:0] exp_lines, input int hold);
    exp_t e;
    bit   seen;
    int   extra;
    exp_q.push_back('{ok: exp_ok, lines: exp_lines});
    @(posedge clk);
    #1;
    bus.avr_ctrl   = cmd;
    bus.avr_strobe = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (bus.cmd_ack || bus.cmd_err) seen = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: no ack/err within 4 cycles, required ok=%0b", name, e.ok);
    end else begin
      if ({bus.cmd_ack, bus.cmd_err} !== {e.ok, ~e.ok}) begin
        fails++;
        $display("FAIL %s: ack/err=%b%b required %b%b", name, bus.cmd_ack, bus.cmd_err, e.ok, ~e.ok);
      end
      checks++;
      if (bus.ctrl_lines !== e.lines) begin
        fails++;
        $display("FAIL %s lines: got %h required %h", name, bus.ctrl_lines, e.lines);
      end
    end
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.cmd_ack || bus.cmd_err) extra++;
    end
    if (hold > 0) begin
      checks++;
      if (extra != 0) begin
        fails++;
        $display("FAIL %s held strobe: %0d extra ack/err pulses, required 0", name, extra);
      end
    end
    bus.avr_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) idle = 1'b1;
    end
    checks++;
    if (!idle) begin
      fails++;
      $display("FAIL %s: busy still %b after 20 cycles, required 0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.avr_ctrl   = 8'h00;
    bus.avr_strobe = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ctrl_lines !== 8'hA5) begin
      fails++; $display("FAIL reset lines: got %h required a5", bus.ctrl_lines);
    end
    checks++;
    if ({bus.busy, bus.cmd_ack, bus.cmd_err} !== 3'b000) begin
      fails++; $display("FAIL reset flags: busy/ack/err=%b%b%b required 000", bus.busy, bus.cmd_ack, bus.cmd_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_set_high();
    do_cmd("hi_line2", make_cmd(OP_HI, 6'd2), 1'b1, 8'hA5, 0);
    @(negedge clk);
    checks++;
    if (bus.cmd_ack !== 1'b0) begin
      fails++; $display("FAIL ack_single_cycle: ack=%b required 0", bus.cmd_ack);
    end
  endtask

  task automatic test_hold_toggle();
    do_cmd("lo_line0", 8'h00, 1'b1, 8'hA4, 0);
    do_cmd("lo_line2", 8'h02, 1'b1, 8'hA0, 0);
    do_cmd("lo_line5", 8'h05, 1'b1, 8'h80, 0);
    do_cmd("lo_line7", 8'h07, 1'b1, 8'h00, 0);
    do_cmd("toggle3_held", 8'h83, 1'b1, 8'h08, 9);
    @(negedge clk);
    checks++;
    if (bus.ctrl_lines !== 8'h08) begin
      fails++; $display("FAIL toggle3_after_hold: got %h required 08", bus.ctrl_lines);
    end
    do_cmd("toggle3_back", make_cmd(OP_TOGGLE, 6'd3), 1'b1, 8'h00, 0);
  endtask

  task automatic test_pulse_timing();
    do_cmd("pulse1", 8'hC1, 1'b1, 8'h02, 0);
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++; $display("FAIL pulse busy start: got %b required 1", bus.busy);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.ctrl_lines !== 8'h02 || bus.busy !== 1'b1) begin
        fails++; $display("FAIL pulse cycle %0d: lines=%h busy=%b required 02/1", k, bus.ctrl_lines, bus.busy);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.ctrl_lines !== 8'h00 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL pulse end: lines=%h busy=%b required 00/0", bus.ctrl_lines, bus.busy);
    end
  endtask

  task automatic test_pulse_conflicts();
    do_cmd("pulse_a", 8'hC1, 1'b1, 8'h02, 0);
    do_cmd("hi5_in_pulse", 8'h45, 1'b1, 8'h22, 0);
    // Lands on the completion edge: still rejected, restore applies.
    do_cmd("lo1_in_pulse", 8'h01, 1'b0, 8'h20, 0);
    wait_idle("pulse_a_idle");
    do_cmd("pulse_b", 8'hC1, 1'b1, 8'h22, 0);
    do_cmd("lo1_mid_pulse", 8'h01, 1'b0, 8'h22, 0);
    do_cmd("pulse2_in_pulse", 8'hC2, 1'b0, 8'h20, 0);
    wait_idle("pulse_b_idle");
    do_cmd("pulse_c", 8'hC1, 1'b1, 8'h22, 0);
    do_cmd("restore_in_pulse", 8'h7F, 1'b0, 8'h22, 0);
    do_cmd("lo5_at_completion", 8'h05, 1'b1, 8'h00, 0);
    wait_idle("pulse_c_idle");
  endtask

  task automatic test_special();
    do_cmd("hi5", 8'h45, 1'b1, 8'h20, 0);
    do_cmd("idx_out_of_range", 8'h08, 1'b0, 8'h20, 0);
    do_cmd("nop", 8'h3F, 1'b1, 8'h20, 0);
    do_cmd("special_toggle", 8'hBF, 1'b0, 8'h20, 0);
    do_cmd("restore", 8'h7F, 1'b1, 8'hA5, 0);
  endtask

  task automatic test_reset_mid_pulse();
    do_cmd("pulse0", 8'hC0, 1'b1, 8'hA4, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ctrl_lines !== 8'hA5 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid_pulse: lines=%h busy=%b required a5/0", bus.ctrl_lines, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    do_cmd("pulse0_after_reset", 8'hC0, 1'b1, 8'hA4, 0);
    wait_idle("pulse0_after_reset_idle");
    checks++;
    if (bus.ctrl_lines !== 8'hA5) begin
      fails++; $display("FAIL pulse0_restored: got %h required a5", bus.ctrl_lines);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_set_high();
    test_hold_toggle();
    test_pulse_timing();
    test_pulse_conflicts();
    test_special();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
